// File: rtl/a2d_intf.sv
// SPI master for the ADC128S: two 16-bit frames per conversion (command, then command + readback),
// SCLK = clk/32, 32-clk inter-frame gap, 12-bit result with a sticky completion flag.
module a2d_intf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        strt_cnv,
  input  logic [2:0]  chnnl,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic        cnv_cmplt,
  output logic [11:0] res
);

  typedef enum logic [1:0] {IDLE, XFER1, GAP, XFER2} state_t;

  localparam logic [4:0] SCLK_LOAD = 5'b10111;
  localparam logic [4:0] SCLK_PRE_RISE = 5'b01111;
  localparam logic [4:0] SCLK_PRE_FALL = 5'b11111;

  state_t      state_q, state_d;
  logic [2:0]  chnnl_q, chnnl_d;
  logic [15:0] shft_q, shft_d;
  logic [4:0]  sclk_div_q, sclk_div_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [4:0]  gap_cnt_q, gap_cnt_d;
  logic        fall_seen_q, fall_seen_d;
  logic        miso_smpl_q, miso_smpl_d;
  logic        ss_n_q, ss_n_d;
  logic        cnv_cmplt_q, cnv_cmplt_d;
  logic [11:0] res_q, res_d;

  logic        in_xfer;
  logic        sclk_rise;
  logic        sclk_fall;
  logic        frame_end;
  logic [15:0] shifted;

  always_comb begin
    state_d     = state_q;
    chnnl_d     = chnnl_q;
    shft_d      = shft_q;
    sclk_div_d  = sclk_div_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    fall_seen_d = fall_seen_q;
    miso_smpl_d = miso_smpl_q;
    ss_n_d      = ss_n_q;
    cnv_cmplt_d = cnv_cmplt_q;
    res_d       = res_q;

    in_xfer   = (state_q == XFER1) || (state_q == XFER2);
    sclk_rise = in_xfer && (sclk_div_q == SCLK_PRE_RISE);
    sclk_fall = in_xfer && (sclk_div_q == SCLK_PRE_FALL);
    frame_end = sclk_fall && (bit_cnt_q == 5'd15);
    shifted   = {shft_q[14:0], miso_smpl_q};

    unique case (state_q)
      IDLE: begin
        if (strt_cnv) begin
          chnnl_d     = chnnl;
          shft_d      = {2'b00, chnnl, 11'h000};
          sclk_div_d  = SCLK_LOAD;
          bit_cnt_d   = '0;
          fall_seen_d = 1'b0;
          ss_n_d      = 1'b0;
          cnv_cmplt_d = 1'b0;
          state_d     = XFER1;
        end
      end

      XFER1, XFER2: begin
        if (frame_end) begin
          // 16th shift; sclk_div is held at 11111 so SCLK stays high with no trailing fall
          shft_d    = shifted;
          bit_cnt_d = bit_cnt_q + 5'd1;
          ss_n_d    = 1'b1;
          if (state_q == XFER1) begin
            gap_cnt_d = '0;
            state_d   = GAP;
          end else begin
            res_d       = shifted[11:0];
            cnv_cmplt_d = 1'b1;
            state_d     = IDLE;
          end
        end else begin
          sclk_div_d = sclk_div_q + 5'd1;
          if (sclk_rise) begin
            miso_smpl_d = MISO;
          end
          if (sclk_fall) begin
            // leading fall of a frame only marks the start; no data captured yet
            if (fall_seen_q) begin
              shft_d    = shifted;
              bit_cnt_d = bit_cnt_q + 5'd1;
            end else begin
              fall_seen_d = 1'b1;
            end
          end
        end
      end

      GAP: begin
        gap_cnt_d = gap_cnt_q + 5'd1;
        if (gap_cnt_q == 5'd31) begin
          shft_d      = {2'b00, chnnl_q, 11'h000};
          sclk_div_d  = SCLK_LOAD;
          bit_cnt_d   = '0;
          fall_seen_d = 1'b0;
          ss_n_d      = 1'b0;
          state_d     = XFER2;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      chnnl_q     <= '0;
      shft_q      <= '0;
      sclk_div_q  <= '1;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      fall_seen_q <= 1'b0;
      miso_smpl_q <= 1'b0;
      ss_n_q      <= 1'b1;
      cnv_cmplt_q <= 1'b0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      chnnl_q     <= chnnl_d;
      shft_q      <= shft_d;
      sclk_div_q  <= sclk_div_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      fall_seen_q <= fall_seen_d;
      miso_smpl_q <= miso_smpl_d;
      ss_n_q      <= ss_n_d;
      cnv_cmplt_q <= cnv_cmplt_d;
      res_q       <= res_d;
    end
  end

  assign SS_n      = ss_n_q;
  assign SCLK      = sclk_div_q[4];
  assign MOSI      = shft_q[15];
  assign cnv_cmplt = cnv_cmplt_q;
  assign res       = res_q;

endmodule

// File: tb/tb_a2d_intf.sv
// Self-checking bench for a2d_intf: ADC128S-style MISO model driven by the observed SPI pins,
// table-driven conversions, randomized conversions and hand-written busy/abort/back-to-back sequences.
module tb_a2d_intf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        MISO;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        cnv_cmplt;
  logic [11:0] res;

  always #5 clk = ~clk;

  a2d_intf dut (
    .clk(clk), .rst_n(rst_n), .strt_cnv(strt_cnv), .chnnl(chnnl), .MISO(MISO),
    .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .cnv_cmplt(cnv_cmplt), .res(res)
  );

  localparam int M_ADC  = 0;
  localparam int M_ONE  = 1;
  localparam int M_ZERO = 2;

  typedef struct {
    logic [2:0]  ch;
    int          mode;
    logic [11:0] ana;
    logic [11:0] exp_res;
  } vec_t;

  int          n_vec = 0;
  int          n_err = 0;
  logic [11:0] analog [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One full conversion; the bench acts as the ADC and measures every pin event relative to E0.
  task automatic run_conv(input logic [2:0] ch, input int mode, input bit busy,
                          input logic [11:0] exp_res);
    int          t;
    logic        prev_ss, prev_sclk;
    int          frame, bitidx;
    logic [15:0] word;
    logic [15:0] mw [2];
    int          rises [2];
    int          first_rise, first_fall;
    int          ss_rise [2];
    int          n_ss_rise;
    int          ss_fall2;
    int          cmplt_t;
    logic [11:0] res_seen;
    logic [15:0] cmd;

    cmd = {2'b00, ch, 11'h000};
    mw[0] = '0; mw[1] = '0; rises[0] = 0; rises[1] = 0;
    first_rise = -1; first_fall = -1; ss_rise[0] = -1; ss_rise[1] = -1;
    n_ss_rise = 0; ss_fall2 = -1; cmplt_t = -1; res_seen = '0;

    chnnl = ch;
    strt_cnv = 1'b1;
    @(posedge clk); #1;
    strt_cnv = 1'b0;
    chnnl = 3'($urandom);
    check("ss_low_at_e0", 32'(SS_n), 32'd0);
    check("cmplt_clear_at_e0", 32'(cnv_cmplt), 32'd0);

    prev_ss = SS_n; prev_sclk = SCLK;
    frame = 0; bitidx = 0;
    word = {4'h0, 12'($urandom)};
    MISO = (mode == M_ONE) ? 1'b1 : (mode == M_ZERO) ? 1'b0 : word[15];
    t = 0;
    while (cmplt_t < 0 && t < 1200) begin
      @(posedge clk); #1;
      t++;
      if (prev_ss && !SS_n) begin
        ss_fall2 = t;
        frame = 1;
        bitidx = 0;
        word = {4'h0, analog[mw[0][13:11]]};
      end
      if (!prev_ss && SS_n && n_ss_rise < 2) begin
        ss_rise[n_ss_rise] = t;
        n_ss_rise++;
      end
      if (!SS_n && !prev_sclk && SCLK) begin
        rises[frame]++;
        mw[frame] = {mw[frame][14:0], MOSI};
        if (frame == 0 && first_rise < 0) first_rise = t;
        bitidx++;
      end
      if (!SS_n && prev_sclk && !SCLK && frame == 0 && first_fall < 0) first_fall = t;
      if (cnv_cmplt) begin
        cmplt_t = t;
        res_seen = res;
      end
      prev_ss = SS_n;
      prev_sclk = SCLK;
      strt_cnv = busy && (t == 100 || t == 530 || t == 800);
      if (mode == M_ONE) MISO = 1'b1;
      else if (mode == M_ZERO) MISO = 1'b0;
      else MISO = (bitidx < 16) ? word[15 - bitidx] : 1'b0;
    end
    strt_cnv = 1'b0;

    check("first_sclk_fall", 32'(first_fall), 32'd9);
    check("first_sclk_rise", 32'(first_rise), 32'd25);
    check("frame1_rises", 32'(rises[0]), 32'd16);
    check("frame2_rises", 32'(rises[1]), 32'd16);
    check("frame1_mosi_cmd", 32'(mw[0]), 32'(cmd));
    check("frame2_mosi_cmd", 32'(mw[1]), 32'(cmd));
    check("frame1_ss_high", 32'(ss_rise[0]), 32'd521);
    check("frame2_ss_low", 32'(ss_fall2), 32'd553);
    check("frame2_ss_high", 32'(ss_rise[1]), 32'd1074);
    check("cmplt_time", 32'(cmplt_t), 32'd1074);
    check("result", 32'(res_seen), 32'(exp_res));
  endtask

  task automatic hold_check(input logic [11:0] exp_res);
    repeat (20) @(posedge clk);
    #1;
    check("cmplt_holds", 32'(cnv_cmplt), 32'd1);
    check("res_holds", 32'(res), 32'(exp_res));
    check("ss_idle_high", 32'(SS_n), 32'd1);
  endtask

  initial begin
    vec_t        vecs [6];
    int          toggles;
    logic        last_sclk;
    logic [2:0]  rch;
    logic [11:0] rval;

    rst_n = 1'b0; strt_cnv = 1'b0; chnnl = '0; MISO = 1'b0;
    for (int i = 0; i < 8; i++) analog[i] = 12'($urandom);

    repeat (2) @(posedge clk);
    #1;
    check("rst_ss_n", 32'(SS_n), 32'd1);
    check("rst_sclk", 32'(SCLK), 32'd1);
    check("rst_mosi", 32'(MOSI), 32'd0);
    check("rst_cmplt", 32'(cnv_cmplt), 32'd0);
    check("rst_res", 32'(res), 32'h000);
    rst_n = 1'b1;

    toggles = 0;
    last_sclk = SCLK;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (SCLK !== last_sclk || SS_n !== 1'b1) toggles++;
      last_sclk = SCLK;
    end
    check("idle_no_toggles", 32'(toggles), 32'd0);

    vecs[0] = '{ch: 3'd5, mode: M_ADC,  ana: 12'h123, exp_res: 12'h123};
    vecs[1] = '{ch: 3'd0, mode: M_ONE,  ana: 12'h000, exp_res: 12'hFFF};
    vecs[2] = '{ch: 3'd7, mode: M_ZERO, ana: 12'h000, exp_res: 12'h000};
    vecs[3] = '{ch: 3'd1, mode: M_ADC,  ana: 12'h800, exp_res: 12'h800};
    vecs[4] = '{ch: 3'd6, mode: M_ADC,  ana: 12'h001, exp_res: 12'h001};
    vecs[5] = '{ch: 3'd3, mode: M_ADC,  ana: 12'hABC, exp_res: 12'hABC};

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].mode == M_ADC) analog[vecs[i].ch] = vecs[i].ana;
      run_conv(vecs[i].ch, vecs[i].mode, 1'b0, vecs[i].exp_res);
      if (i != 5) hold_check(vecs[i].exp_res);
    end

    // back-to-back: the edge right after completion must accept a new start
    rch = 3'd4;
    analog[rch] = 12'h5A5;
    run_conv(rch, M_ADC, 1'b0, 12'h5A5);

    // start requests while busy are ignored
    analog[2] = 12'h3C7;
    run_conv(3'd2, M_ADC, 1'b1, 12'h3C7);
    hold_check(12'h3C7);

    for (int i = 0; i < 5; i++) begin
      rch = 3'($urandom);
      rval = 12'($urandom);
      analog[rch] = rval;
      run_conv(rch, M_ADC, 1'b0, rval);
    end

    // abort mid-frame with reset
    chnnl = 3'd6;
    strt_cnv = 1'b1;
    @(posedge clk); #1;
    strt_cnv = 1'b0;
    check("abort_ss_low", 32'(SS_n), 32'd0);
    repeat (299) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_ss_n", 32'(SS_n), 32'd1);
    check("abort_sclk", 32'(SCLK), 32'd1);
    check("abort_mosi", 32'(MOSI), 32'd0);
    check("abort_res", 32'(res), 32'h000);
    check("abort_cmplt", 32'(cnv_cmplt), 32'd0);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("abort_cmplt_stays0", 32'(cnv_cmplt), 32'd0);
    check("abort_ss_stays_high", 32'(SS_n), 32'd1);
    analog[6] = 12'hD2E;
    run_conv(3'd6, M_ADC, 1'b0, 12'hD2E);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/a2d_intf.md
# a2d_intf

SPI master that drives the ADC128S 12-bit A2D converter. On a start request it runs the two 16-bit SPI transactions the converter needs and returns the 12-bit result with a completion flag.
- Transaction 1 sends the channel command.
- Transaction 2 sends the command again and clocks the conversion back.

It sits between the system logic that consumes samples and the A2D's SS_n/SCLK/MOSI/MISO pins.

## Interface
- Parameters: none. The SCLK divide ratio (32) and inter-frame gap (32 clk) are fixed.
- clk  input  1  system clock; all logic is on the rising edge
- rst_n  input  1  reset, synchronous, active-low
- strt_cnv  input  1  start request; sampled only in IDLE
- chnnl  input  3  channel to convert; latched on the accepting edge
- MISO  input  1  serial data from the A2D
- SS_n  output  1  active-low slave select; reset value 1
- SCLK  output  1  serial clock, idles high; reset value 1
- MOSI  output  1  serial data to the A2D, equal to shft[15]; reset value 0
- cnv_cmplt  output  1  conversion done; reset value 0
- res  output  12  last conversion result; reset value 12'h000

## Operation
- States: IDLE, XFER1, GAP, XFER2. The sampled reset forces IDLE and clears all registers, whatever the current state.
- Command word: {2'b00, chnnl, 11'h000}. It is loaded into the 16-bit shift register shft on entry to XFER1 and again on entry to XFER2.
- Clock divider: 5-bit sclk_div, with SCLK = sclk_div[4].
  - Loaded with 5'b10111 on entry to each XFER state.
  - Increments by 1 every clk while in an XFER state.
- Rising SCLK: the edge where sclk_div goes 01111->10000. MISO is captured into miso_smpl on this edge.
- Falling SCLK: the edge where sclk_div goes 11111->00000.
  - The first fall of each frame does not shift.
  - Every later fall does shft <= {shft[14:0], miso_smpl} and increments the 5-bit bit_cnt.
- Frame end: when bit_cnt==15 and sclk_div==11111, the next edge does all of the following:
  - performs the 16th shift;
  - holds sclk_div at 11111, so there is no falling SCLK;
  - drives SS_n high;
  - changes state.
- A frame therefore has exactly 16 SCLK rising edges and 16 shifts.
- IDLE, when strt_cnv=1:
  - latch chnnl and load shft;
  - load sclk_div; clear bit_cnt;
  - SS_n goes low; cnv_cmplt goes 0;
  - go to XFER1.
- XFER1: at frame end go to GAP. The received word is discarded.
- GAP: counts 32 clk with SS_n=1 and SCLK=1, then reloads shft, sclk_div and bit_cnt, drives SS_n low, and goes to XFER2.
- XFER2: at frame end do all of the following, then go to IDLE:
  - res <= {shft[10:0], miso_smpl}[11:0], i.e. the low 12 bits of the final shifted word;
  - cnv_cmplt <= 1.
- cnv_cmplt stays 1 and res holds until the next accepted strt_cnv. That edge clears cnv_cmplt; res keeps its old value until overwritten.
- strt_cnv outside IDLE is ignored; there is no queueing.
- Reset mid-frame: on the next edge SS_n=1, SCLK=1, MOSI=0, res=0, cnv_cmplt=0. The partial frame is abandoned.

## Timing
- E0 is the edge that accepts strt_cnv. Offsets below are in clk edges after E0.
- SS_n goes low at E0.
- First frame:
  - First SCLK fall at E0+9.
  - Rises at E0+25+32k, for k=0..15.
  - SS_n goes high at E0+521, so it is low for 521 clocks.
- GAP: SS_n is high for exactly 32 clocks; SS_n goes low again at E0+553.
- Second frame: same shape; SS_n goes high at E0+1074.
- cnv_cmplt rises and res updates on the same edge, E0+1074.
- IDLE is re-entered on that edge, so strt_cnv at E0+1075 is accepted.
- SCLK high time is 16 clk and low time is 16 clk.
- MOSI changes only on falling-SCLK edges, on frame entry, or on reset, so it is stable around every rising edge.

## Test plan
- Reset: assert rst_n=0 for 2 clk -> SS_n=1, SCLK=1, MOSI=0, cnv_cmplt=0, res=000; no SCLK toggles while IDLE.
- Command encoding: chnnl=5, pulse strt_cnv; bench samples MOSI on each SCLK rise -> 16'h2800 in both frames; exactly 16 rises per frame; SS_n low for 521 clk; gap = 32 clk.
- Loopback constants: MISO tied to 1 -> res=12'hFFF at E0+1074 with cnv_cmplt=1; MISO tied to 0 -> res=12'h000.
- ADC128S model with the channel-3 entry of analog.dat = 12'hABC; chnnl=3 -> res=12'hABC; cnv_cmplt holds until the next strt_cnv; back-to-back start at E0+1075 is accepted.
- Busy/abort:
  - strt_cnv pulses during XFER1, GAP and XFER2 -> no effect on timing; result as normal.
  - rst_n=0 at E0+300 -> SS_n=1 on the next edge, cnv_cmplt stays 0, and a new conversion afterwards completes correctly.
